// File: rtl/rename_pkg.sv
// ----------------------------------------------------------------------------
// rename_pkg
// Shared typedefs and constants for the rename stage.
//   instStruct     : decoded instruction as it leaves decode (architectural regs)
//   dispatchStruct : renamed instruction as it goes to dispatch (physical regs)
//   NUM_PREGS / PREG_W / FREELIST_DEPTH size the physical register file,
//   the RAT entries and the free list.
// ----------------------------------------------------------------------------
package rename_pkg;

    localparam int NUM_PREGS      = 64;
    localparam int PREG_W         = 6;
    localparam int FREELIST_DEPTH = 32;
    localparam int FL_IDX_W       = 5;
    localparam int ARCH_REGS      = 32;
    localparam int AREG_W         = 5;

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [AREG_W-1:0] areg_t;

    typedef struct packed {
        logic       RegWrite;
        logic       MemRead;
        logic       MemWrite;
        logic       MemtoReg;
        logic       Branch;
        logic       ALUSrc;
        logic [1:0] ALUOp;
    } ctrlStruct;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        areg_t       rd;
        areg_t       rs1;
        areg_t       rs2;
        logic [31:0] imm;
        ctrlStruct   control;
    } instStruct;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        preg_t       rd;
        preg_t       rs1;
        preg_t       rs2;
        preg_t       rd_old;
        logic [31:0] imm;
        ctrlStruct   control;
    } dispatchStruct;

    // A lane consumes a physical register only when it really writes a
    // non-x0 destination.
    function automatic logic is_alloc(instStruct i);
        return i.control.RegWrite && (i.rd != '0);
    endfunction

    // Copy the fields that rename does not touch; register fields start at 0.
    function automatic dispatchStruct pass_through(instStruct i);
        dispatchStruct d;
        d         = '0;
        d.pc      = i.pc;
        d.opcode  = i.opcode;
        d.funct3  = i.funct3;
        d.funct7  = i.funct7;
        d.imm     = i.imm;
        d.control = i.control;
        return d;
    endfunction

endpackage

// File: rtl/rename_freelist.sv
// ----------------------------------------------------------------------------
// rename_freelist
// Circular FIFO of free physical registers, two pops and two pushes per cycle.
//   pop_cnt            : number of registers taken this cycle (0..2)
//   pop_preg_0/1       : the two oldest free registers (valid when count >= 2)
//   push_valid_a/b,
//   push_preg_a/b      : registers returned this cycle, a queued before b;
//                        a returned preg of 0 is ignored
//   count              : registered number of free entries (0..32)
// Head/tail are 6 bits: 5-bit index plus a wrap bit. Reset leaves the list
// full with pregs 32..63.
// ----------------------------------------------------------------------------
module rename_freelist
    import rename_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        pop_cnt,
    output logic [PREG_W-1:0] pop_preg_0,
    output logic [PREG_W-1:0] pop_preg_1,
    input  logic              push_valid_a,
    input  logic [PREG_W-1:0] push_preg_a,
    input  logic              push_valid_b,
    input  logic [PREG_W-1:0] push_preg_b,
    output logic [PREG_W-1:0] count
);

    preg_t             entries_q [FREELIST_DEPTH];
    preg_t             entries_d [FREELIST_DEPTH];
    logic [PREG_W-1:0] head_q, head_d;
    logic [PREG_W-1:0] tail_q, tail_d;
    logic [PREG_W-1:0] count_q, count_d;
    logic [PREG_W-1:0] head_nxt;
    logic              push_a_ok, push_b_ok;

    assign push_a_ok  = push_valid_a && (push_preg_a != '0);
    assign push_b_ok  = push_valid_b && (push_preg_b != '0);
    assign head_nxt   = head_q + PREG_W'(1);
    assign pop_preg_0 = entries_q[head_q[FL_IDX_W-1:0]];
    assign pop_preg_1 = entries_q[head_nxt[FL_IDX_W-1:0]];
    assign count      = count_q;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it
        // unassigned; that is what keeps this block free of inferred latches.
        entries_d = entries_q;
        head_d    = head_q + PREG_W'(pop_cnt);
        tail_d    = tail_q;
        if (push_a_ok) begin
            entries_d[tail_d[FL_IDX_W-1:0]] = push_preg_a;
            tail_d = tail_d + PREG_W'(1);
        end
        if (push_b_ok) begin
            entries_d[tail_d[FL_IDX_W-1:0]] = push_preg_b;
            tail_d = tail_d + PREG_W'(1);
        end
        count_d = count_q + PREG_W'(push_a_ok) + PREG_W'(push_b_ok) - PREG_W'(pop_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this storage is reset on purpose: the initial pool contents
            // (pregs 32..63) are architectural state, not don't-care data.
            for (int i = 0; i < FREELIST_DEPTH; i++) begin
                entries_q[i] <= PREG_W'(FREELIST_DEPTH + i);
            end
            head_q  <= '0;
            tail_q  <= PREG_W'(FREELIST_DEPTH);   // index 0, wrap bit set: full
            count_q <= PREG_W'(FREELIST_DEPTH);
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before the edge, independent of statement order.
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: rtl/rename_stage.sv
// ----------------------------------------------------------------------------
// rename_stage
// Two-wide register rename: maps architectural registers through a 32x6
// speculative RAT, allocates destinations from rename_freelist and registers
// the renamed pair for dispatch (1-cycle latency, valid/ready on both sides).
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid/in_ready      : decode handshake, in_a older than in_b
//   out_valid/out_ready    : dispatch handshake, out_a/out_b renamed pair
//   ret_valid_a/b,
//   ret_preg_a/b           : ROB retire strobes returning old pregs
//   stall_cnt              : only with RENAME_PERF_EN defined; saturating
//                            count of cycles with in_valid && !in_ready
// ----------------------------------------------------------------------------
module rename_stage
    import rename_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  instStruct         in_a,
    input  instStruct         in_b,
    output logic              in_ready,
    output logic              out_valid,
    output dispatchStruct     out_a,
    output dispatchStruct     out_b,
    input  logic              out_ready,
    input  logic              ret_valid_a,
    input  logic              ret_valid_b,
    input  logic [PREG_W-1:0] ret_preg_a,
    input  logic [PREG_W-1:0] ret_preg_b
`ifdef RENAME_PERF_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    preg_t             rat_q [ARCH_REGS];
    preg_t             rat_d [ARCH_REGS];
    dispatchStruct     out_a_q, out_a_d, out_b_q, out_b_d;
    logic              out_valid_q, out_valid_d;
    dispatchStruct     ren_a, ren_b;
    logic [PREG_W-1:0] fl_count;
    preg_t             fl_pop_0, fl_pop_1;
    preg_t             new_a, new_b;
    logic [1:0]        pop_cnt;
    logic              alloc_a, alloc_b, accept;
    logic              fwd_rs1, fwd_rs2, fwd_rd;

    assign alloc_a  = is_alloc(in_a);
    assign alloc_b  = is_alloc(in_b);
    // Registered count only: registers retired this cycle are not yet usable.
    assign in_ready = (fl_count >= PREG_W'(2)) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign pop_cnt  = accept ? {alloc_a && alloc_b, alloc_a ^ alloc_b} : 2'd0;

    // Lane a always takes the oldest free register; lane b takes the next one
    // only if lane a also allocated.
    assign new_a = alloc_a ? fl_pop_0 : '0;
    assign new_b = !alloc_b ? '0 : (alloc_a ? fl_pop_1 : fl_pop_0);

    // Intra-group bypass: lane b sees lane a's destination before the RAT does.
    assign fwd_rs1 = alloc_a && (in_b.rs1 == in_a.rd);
    assign fwd_rs2 = alloc_a && (in_b.rs2 == in_a.rd);
    assign fwd_rd  = alloc_a && (in_b.rd == in_a.rd);

    rename_freelist u_freelist (
        .clk          (clk),
        .rst_n        (rst_n),
        .pop_cnt      (pop_cnt),
        .pop_preg_0   (fl_pop_0),
        .pop_preg_1   (fl_pop_1),
        .push_valid_a (ret_valid_a),
        .push_preg_a  (ret_preg_a),
        .push_valid_b (ret_valid_b),
        .push_preg_b  (ret_preg_b),
        .count        (fl_count)
    );

    // RAT[0] resets to 0 and is never written, so x0 always reads as preg 0.
    always_comb begin
        ren_a        = pass_through(in_a);
        ren_a.rs1    = rat_q[in_a.rs1];
        ren_a.rs2    = rat_q[in_a.rs2];
        ren_a.rd     = new_a;
        ren_a.rd_old = alloc_a ? rat_q[in_a.rd] : '0;

        ren_b        = pass_through(in_b);
        ren_b.rs1    = fwd_rs1 ? new_a : rat_q[in_b.rs1];
        ren_b.rs2    = fwd_rs2 ? new_a : rat_q[in_b.rs2];
        ren_b.rd     = new_b;
        ren_b.rd_old = !alloc_b ? '0 : (fwd_rd ? new_a : rat_q[in_b.rd]);
    end

    always_comb begin
        rat_d       = rat_q;
        out_valid_d = out_valid_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        if (accept) begin
            // Lane b is written last so it wins when both lanes target one reg.
            if (alloc_a) rat_d[in_a.rd] = new_a;
            if (alloc_b) rat_d[in_b.rd] = new_b;
            out_valid_d = 1'b1;
            out_a_d     = ren_a;
            out_b_d     = ren_b;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat_q[i] <= PREG_W'(i);
            end
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
        end else begin
            rat_q       <= rat_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;

`ifdef RENAME_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid && !in_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rename_stage.sv
// ----------------------------------------------------------------------------
// tb_rename_stage
// Scoreboard bench for rename_stage. A driver issues groups and retires; on
// each accepted group a reference model (RAT array + free-list queue, lanes
// renamed one after the other) pushes the expected renamed pair. A monitor
// compares whenever out_valid is high and pops on the dispatch handshake.
// Define RENAME_PERF_EN to also check stall_cnt.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rename_stage;
    import rename_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    instStruct     in_a = '0;
    instStruct     in_b = '0;
    logic          in_ready;
    logic          out_valid;
    dispatchStruct out_a, out_b;
    logic          out_ready = 1'b0;
    logic          ret_valid_a = 1'b0;
    logic          ret_valid_b = 1'b0;
    preg_t         ret_preg_a = '0;
    preg_t         ret_preg_b = '0;
`ifdef RENAME_PERF_EN
    logic [31:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    rename_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_ready   (out_ready),
        .ret_valid_a (ret_valid_a),
        .ret_valid_b (ret_valid_b),
        .ret_preg_a  (ret_preg_a),
        .ret_preg_b  (ret_preg_b)
`ifdef RENAME_PERF_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        dispatchStruct a;
        dispatchStruct b;
    } grp_t;

    preg_t       m_rat [ARCH_REGS];
    preg_t       m_fl[$];
    preg_t       m_pending[$];
    bit          m_out_valid;
    int unsigned m_stall;
    grp_t        sb[$];

    function automatic void model_reset();
        for (int i = 0; i < ARCH_REGS; i++) m_rat[i] = preg_t'(i);
        m_fl.delete();
        for (int i = 0; i < FREELIST_DEPTH; i++) m_fl.push_back(preg_t'(32 + i));
        m_pending.delete();
        m_out_valid = 1'b0;
        m_stall     = 0;
        sb.delete();
    endfunction

    // Rename one lane against the current model state; calling it for lane a
    // and then lane b gives the in-group dependency behaviour for free.
    function automatic dispatchStruct model_lane(instStruct ins);
        dispatchStruct d;
        d.pc      = ins.pc;
        d.opcode  = ins.opcode;
        d.funct3  = ins.funct3;
        d.funct7  = ins.funct7;
        d.imm     = ins.imm;
        d.control = ins.control;
        d.rs1     = m_rat[ins.rs1];
        d.rs2     = m_rat[ins.rs2];
        if (ins.control.RegWrite && ins.rd != 0) begin
            d.rd_old = m_rat[ins.rd];
            d.rd     = m_fl.pop_front();
            m_rat[ins.rd] = d.rd;
            m_pending.push_back(d.rd_old);
        end else begin
            d.rd     = '0;
            d.rd_old = '0;
        end
        return d;
    endfunction

    function automatic instStruct mk(logic rw, int rd, int rs1, int rs2);
        instStruct i;
        i.pc      = $urandom;
        i.opcode  = 7'($urandom);
        i.funct3  = 3'($urandom);
        i.funct7  = 7'($urandom);
        i.imm     = $urandom;
        i.control = ctrlStruct'(8'($urandom));
        i.control.RegWrite = rw;
        i.rd      = areg_t'(rd);
        i.rs1     = areg_t'(rs1);
        i.rs2     = areg_t'(rs2);
        return i;
    endfunction

    function automatic int rnd_reg();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 31));
        return int'($urandom_range(0, 7));
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic iv, input instStruct a, input instStruct b, input logic ordy,
                         input logic rva, input preg_t pa, input logic rvb, input preg_t pb);
        bit   exp_ready;
        grp_t g;
        @(posedge clk);
        #2;
        in_valid    = iv;
        in_a        = a;
        in_b        = b;
        out_ready   = ordy;
        ret_valid_a = rva;
        ret_preg_a  = pa;
        ret_valid_b = rvb;
        ret_preg_b  = pb;
        #1;
        exp_ready = (m_fl.size() >= 2) && (!m_out_valid || ordy);
        check("in_ready", 128'(in_ready), 128'(exp_ready));
        if (iv && !exp_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (iv && exp_ready) begin
            g.a = model_lane(a);
            g.b = model_lane(b);
            sb.push_back(g);
            m_out_valid = 1'b1;
        end else if (ordy) begin
            m_out_valid = 1'b0;
        end
        if (rva && pa != 0) m_fl.push_back(pa);
        if (rvb && pb != 0) m_fl.push_back(pb);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        ret_valid_a = 1'b0;
        ret_valid_b = 1'b0;
        model_reset();
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_a", 128'(out_a), 128'(0));
        check("rst_out_b", 128'(out_b), 128'(0));
`ifdef RENAME_PERF_EN
        check("rst_stall_cnt", 128'(stall_cnt), 128'(0));
`endif
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_valid_unexpected: got out_valid=1 expected 0 (t=%0t)", $time);
            end else begin
                check("out_a", 128'(out_a), 128'(sb[0].a));
                check("out_b", 128'(out_b), 128'(sb[0].b));
                if (out_ready) sb.delete(0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        instStruct a, b;
        logic      rva, rvb;
        preg_t     pa, pb;
        int        idx;

        model_reset();
        do_reset();

        // Two independent addi's right after reset.
        drive(1'b1, mk(1, 1, 0, 0), mk(1, 2, 0, 0), 1'b1, 1'b0, '0, 1'b0, '0);
        // add x3 then sub x4,x3,x3: lane b sources bypass from lane a.
        drive(1'b1, mk(1, 3, 1, 2), mk(1, 4, 3, 3), 1'b1, 1'b0, '0, 1'b0, '0);
        // Both lanes write x5.
        drive(1'b1, mk(1, 5, 5, 0), mk(1, 5, 5, 3), 1'b1, 1'b0, '0, 1'b0, '0);
        // Store in lane a, write to x0 in lane b: nothing allocates.
        drive(1'b1, mk(0, 7, 5, 4), mk(1, 0, 5, 3), 1'b1, 1'b0, '0, 1'b0, '0);
        // Read x5 back to confirm lane b's mapping stuck.
        drive(1'b1, mk(1, 6, 5, 5), mk(0, 0, 4, 3), 1'b1, 1'b0, '0, 1'b0, '0);
        idle(2);

        // Randomised traffic with retires drawn from displaced registers.
        for (int c = 0; c < 400; c++) begin
            a   = mk(($urandom_range(0, 9) < 8), rnd_reg(), rnd_reg(), rnd_reg());
            b   = mk(($urandom_range(0, 9) < 8), rnd_reg(), rnd_reg(), rnd_reg());
            rva = 1'b0; pa = '0;
            rvb = 1'b0; pb = '0;
            if (m_pending.size() > 0 && $urandom_range(0, 99) < 45) begin
                idx = int'($urandom_range(0, m_pending.size() - 1));
                pa  = m_pending[idx];
                m_pending.delete(idx);
                rva = 1'b1;
            end else if ($urandom_range(0, 99) < 5) begin
                rva = 1'b1;
            end
            if (m_pending.size() > 0 && $urandom_range(0, 99) < 45) begin
                idx = int'($urandom_range(0, m_pending.size() - 1));
                pb  = m_pending[idx];
                m_pending.delete(idx);
                rvb = 1'b1;
            end
            drive(($urandom_range(0, 9) < 8), a, b, ($urandom_range(0, 3) != 0), rva, pa, rvb, pb);
        end
        idle(3);

        // Reset with a group in flight; the next rename must see the reset RAT.
        drive(1'b1, mk(1, 1, 2, 3), mk(1, 2, 1, 1), 1'b0, 1'b0, '0, 1'b0, '0);
        do_reset();

        // Drain the free list: 16 fully allocating groups.
        for (int g = 0; g < 16; g++) begin
            drive(1'b1, mk(1, 1, 1, 2), mk(1, 2, 2, 1), 1'b1, 1'b0, '0, 1'b0, '0);
        end
        drive(1'b1, mk(1, 3, 1, 2), mk(1, 4, 3, 1), 1'b1, 1'b1, preg_t'(40), 1'b0, '0);
        drive(1'b1, mk(1, 3, 1, 2), mk(1, 4, 3, 1), 1'b1, 1'b0, '0, 1'b1, preg_t'(41));
        drive(1'b1, mk(1, 3, 1, 2), mk(1, 4, 3, 1), 1'b1, 1'b0, '0, 1'b0, '0);
        idle(2);

        // Dispatch back-pressure for three cycles.
        do_reset();
        drive(1'b1, mk(1, 8, 1, 2), mk(1, 9, 8, 8), 1'b1, 1'b0, '0, 1'b0, '0);
        for (int s = 0; s < 3; s++) begin
            drive(1'b1, mk(1, 10, 8, 9), mk(1, 11, 10, 1), 1'b0, 1'b0, '0, 1'b0, '0);
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0, '0);
`ifdef RENAME_PERF_EN
        check("stall_cnt", 128'(stall_cnt), 128'(m_stall));
`endif
        drive(1'b1, mk(1, 10, 8, 9), mk(1, 11, 10, 1), 1'b1, 1'b0, '0, 1'b0, '0);
        idle(5);

        check("scoreboard_empty", 128'(sb.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
